// File: rtl/tri_pixel_buffer.sv
// Captures rasterizer pixels into an 8x8 bitmap, counts distinct pixels and serves row reads.
// Optional bounding-box tracking is enabled by defining TRI_PIXBUF_BBOX_EN.
module tri_pixel_buffer (
  input  logic       clk,
  input  logic       reset,
  input  logic       busy,
  input  logic       po,
  input  logic [2:0] xo,
  input  logic [2:0] yo,
  input  logic       rd_en,
  input  logic [2:0] rd_row,
  output logic [7:0] row_data,
  output logic       row_valid,
  output logic       frame_done,
  output logic [6:0] pix_cnt
`ifdef TRI_PIXBUF_BBOX_EN
  ,
  output logic [2:0] bbox_xmin,
  output logic [2:0] bbox_xmax,
  output logic [2:0] bbox_ymin,
  output logic [2:0] bbox_ymax,
  output logic       bbox_valid
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [63:0] bm_q, bm_d;
  logic        busy_dly_q, busy_dly_d;
  logic [7:0]  row_data_q, row_data_d;
  logic        row_valid_q, row_valid_d;
  logic        frame_done_q, frame_done_d;
  logic [6:0]  pix_cnt_q, pix_cnt_d;

  logic       busy_rise;
  logic       start_frame;
  logic       capture_en;
  logic       frame_end;
  logic       rd_allow;
  logic [5:0] pix_idx;

  assign busy_rise = busy && !busy_dly_q;
  assign pix_idx   = {yo, xo};

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (busy_rise) state_d = CAPTURE;
      CAPTURE: if (!busy)     state_d = DONE;
      DONE:    if (busy_rise) state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: decoded controls; a capture start takes priority over a read
  always_comb begin
    start_frame = (state_q != CAPTURE) && busy_rise;
    capture_en  = (state_q == CAPTURE);
    frame_end   = (state_q == CAPTURE) && !busy;
    rd_allow    = (state_q != CAPTURE) && !busy_rise;
  end

`ifdef TRI_PIXBUF_BBOX_EN
  logic [2:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [2:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic       bbv_q, bbv_d;
`endif

  always_comb begin
    bm_d         = bm_q;
    pix_cnt_d    = pix_cnt_q;
    busy_dly_d   = busy;
    frame_done_d = frame_end;
    row_data_d   = row_data_q;
    row_valid_d  = 1'b0;
`ifdef TRI_PIXBUF_BBOX_EN
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    bbv_d  = bbv_q;
`endif
    if (start_frame) begin
      bm_d      = '0;
      pix_cnt_d = '0;
`ifdef TRI_PIXBUF_BBOX_EN
      xmin_d = 3'd7;
      xmax_d = 3'd0;
      ymin_d = 3'd7;
      ymax_d = 3'd0;
      bbv_d  = 1'b0;
`endif
    end else if (capture_en && po) begin
      bm_d[pix_idx] = 1'b1;
      // Only first hits count; 64 is the ceiling since the bitmap has 64 bits
      if (!bm_q[pix_idx] && (pix_cnt_q != 7'd64))
        pix_cnt_d = pix_cnt_q + 7'd1;
`ifdef TRI_PIXBUF_BBOX_EN
      xmin_d = (xo < xmin_q) ? xo : xmin_q;
      xmax_d = (xo > xmax_q) ? xo : xmax_q;
      ymin_d = (yo < ymin_q) ? yo : ymin_q;
      ymax_d = (yo > ymax_q) ? yo : ymax_q;
      bbv_d  = 1'b1;
`endif
    end
    if (rd_allow && rd_en) begin
      row_data_d  = bm_q[{rd_row, 3'b000} +: 8];
      row_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bm_q         <= '0;
      pix_cnt_q    <= '0;
      busy_dly_q   <= 1'b0;
      frame_done_q <= 1'b0;
      row_data_q   <= '0;
      row_valid_q  <= 1'b0;
    end else begin
      bm_q         <= bm_d;
      pix_cnt_q    <= pix_cnt_d;
      busy_dly_q   <= busy_dly_d;
      frame_done_q <= frame_done_d;
      row_data_q   <= row_data_d;
      row_valid_q  <= row_valid_d;
    end
  end

`ifdef TRI_PIXBUF_BBOX_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xmin_q <= 3'd7;
      xmax_q <= 3'd0;
      ymin_q <= 3'd7;
      ymax_q <= 3'd0;
      bbv_q  <= 1'b0;
    end else begin
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      bbv_q  <= bbv_d;
    end
  end

  assign bbox_xmin  = xmin_q;
  assign bbox_xmax  = xmax_q;
  assign bbox_ymin  = ymin_q;
  assign bbox_ymax  = ymax_q;
  assign bbox_valid = bbv_q;
`endif

  assign row_data   = row_data_q;
  assign row_valid  = row_valid_q;
  assign frame_done = frame_done_q;
  assign pix_cnt    = pix_cnt_q;

endmodule

// File: tb/tb_tri_pixel_buffer.sv
// Directed bench for tri_pixel_buffer; covers the bbox outputs when TRI_PIXBUF_BBOX_EN is defined.
module tb_tri_pixel_buffer;

  logic       clk;
  logic       reset;
  logic       busy;
  logic       po;
  logic [2:0] xo;
  logic [2:0] yo;
  logic       rd_en;
  logic [2:0] rd_row;
  logic [7:0] row_data;
  logic       row_valid;
  logic       frame_done;
  logic [6:0] pix_cnt;
`ifdef TRI_PIXBUF_BBOX_EN
  logic [2:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
  logic       bbox_valid;
`endif

  int n_tests;
  int n_fail;

  tri_pixel_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .busy       (busy),
    .po         (po),
    .xo         (xo),
    .yo         (yo),
    .rd_en      (rd_en),
    .rd_row     (rd_row),
    .row_data   (row_data),
    .row_valid  (row_valid),
    .frame_done (frame_done),
    .pix_cnt    (pix_cnt)
`ifdef TRI_PIXBUF_BBOX_EN
    ,
    .bbox_xmin  (bbox_xmin),
    .bbox_xmax  (bbox_xmax),
    .bbox_ymin  (bbox_ymin),
    .bbox_ymax  (bbox_ymax),
    .bbox_valid (bbox_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs set afterwards are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    busy = 1'b1;
    step();
    po = 1'b1; xo = 3'd4; yo = 3'd3;
    step();
    po = 1'b0;
    step();
    n_tests++;
    if (pix_cnt !== 7'd1) begin
      n_fail++; $display("FAIL reset_precnt: pix_cnt=%0d expected 1", pix_cnt);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (pix_cnt !== 7'd0 || frame_done !== 1'b0 || row_valid !== 1'b0 || row_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: cnt=%0d done=%b vld=%b data=%h expected 0/0/0/00",
               pix_cnt, frame_done, row_valid, row_data);
    end
    busy = 1'b0;
    step();
    reset = 1'b1;
    step();
    rd_en = 1'b1; rd_row = 3'd3;
    step();
    rd_en = 1'b0;
    n_tests++;
    if (row_valid !== 1'b1 || row_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_read_row3: vld=%b data=%h expected 1/00", row_valid, row_data);
    end
    step();
    n_tests++;
    if (row_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_read_drop: vld=%b expected 0", row_valid);
    end
  endtask

  task automatic test_basic_frame();
    logic [2:0] px [4] = '{3'd0, 3'd1, 3'd2, 3'd1};
    logic [2:0] py [4] = '{3'd0, 3'd0, 3'd0, 3'd1};
    busy = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      po = 1'b1; xo = px[i]; yo = py[i];
      step();
    end
    po = 1'b0; busy = 1'b0;
    n_tests++;
    if (frame_done !== 1'b0 || pix_cnt !== 7'd4) begin
      n_fail++; $display("FAIL basic_midframe: done=%b cnt=%0d expected 0/4", frame_done, pix_cnt);
    end
    step();
    n_tests++;
    if (frame_done !== 1'b1 || pix_cnt !== 7'd4) begin
      n_fail++; $display("FAIL basic_done: done=%b cnt=%0d expected 1/4", frame_done, pix_cnt);
    end
    step();
    n_tests++;
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_pulse: done=%b expected 0", frame_done);
    end
    rd_en = 1'b1; rd_row = 3'd0;
    step();
    n_tests++;
    if (row_valid !== 1'b1 || row_data !== 8'h07) begin
      n_fail++; $display("FAIL basic_row0: vld=%b data=%h expected 1/07", row_valid, row_data);
    end
    rd_row = 3'd1;
    step();
    rd_en = 1'b0;
    n_tests++;
    if (row_valid !== 1'b1 || row_data !== 8'h02) begin
      n_fail++; $display("FAIL basic_row1: vld=%b data=%h expected 1/02", row_valid, row_data);
    end
    step();
    n_tests++;
    if (row_valid !== 1'b0 || row_data !== 8'h02) begin
      n_fail++; $display("FAIL basic_hold: vld=%b data=%h expected 0/02", row_valid, row_data);
    end
  endtask

  task automatic test_duplicate();
    busy = 1'b1;
    step();
    n_tests++;
    if (pix_cnt !== 7'd0) begin
      n_fail++; $display("FAIL dup_start_clear: cnt=%0d expected 0", pix_cnt);
    end
    po = 1'b1; xo = 3'd5; yo = 3'd5;
    step();
    step();
    po = 1'b0; busy = 1'b0;
    step();
    n_tests++;
    if (frame_done !== 1'b1 || pix_cnt !== 7'd1) begin
      n_fail++; $display("FAIL dup_count: done=%b cnt=%0d expected 1/1", frame_done, pix_cnt);
    end
    po = 1'b1; xo = 3'd0; yo = 3'd5;
    step();
    po = 1'b0;
    step();
    n_tests++;
    if (pix_cnt !== 7'd1) begin
      n_fail++; $display("FAIL dup_ignored_po: cnt=%0d expected 1", pix_cnt);
    end
    rd_en = 1'b1; rd_row = 3'd5;
    step();
    rd_en = 1'b0;
    n_tests++;
    if (row_valid !== 1'b1 || row_data !== 8'h20) begin
      n_fail++; $display("FAIL dup_row5: vld=%b data=%h expected 1/20", row_valid, row_data);
    end
  endtask

  task automatic test_full_grid();
    busy = 1'b1;
    step();
    for (int i = 0; i < 64; i++) begin
      po = 1'b1; xo = 3'(i % 8); yo = 3'(i / 8);
      if (i == 63) busy = 1'b0;
      step();
    end
    po = 1'b0;
    n_tests++;
    if (frame_done !== 1'b1 || pix_cnt !== 7'd64) begin
      n_fail++; $display("FAIL full_done: done=%b cnt=%0d expected 1/64", frame_done, pix_cnt);
    end
    for (int r = 0; r < 8; r++) begin
      rd_en = 1'b1; rd_row = 3'(r);
      step();
      n_tests++;
      if (row_valid !== 1'b1 || row_data !== 8'hFF) begin
        n_fail++; $display("FAIL full_row%0d: vld=%b data=%h expected 1/FF", r, row_valid, row_data);
      end
    end
    rd_en = 1'b0;
    step();
  endtask

  task automatic test_collision();
    busy = 1'b1; rd_en = 1'b1; rd_row = 3'd2;
    po = 1'b1; xo = 3'd3; yo = 3'd3;
    step();
    po = 1'b0;
    n_tests++;
    if (row_valid !== 1'b0 || row_data !== 8'hFF || pix_cnt !== 7'd0) begin
      n_fail++; $display("FAIL coll_read_drop: vld=%b data=%h cnt=%0d expected 0/FF/0",
                         row_valid, row_data, pix_cnt);
    end
    step();
    n_tests++;
    if (row_valid !== 1'b0) begin
      n_fail++; $display("FAIL coll_capture_read: vld=%b expected 0", row_valid);
    end
    rd_en = 1'b0; busy = 1'b0;
    step();
    n_tests++;
    if (frame_done !== 1'b1 || pix_cnt !== 7'd0) begin
      n_fail++; $display("FAIL coll_empty_frame: done=%b cnt=%0d expected 1/0", frame_done, pix_cnt);
    end
    rd_en = 1'b1; rd_row = 3'd3;
    step();
    rd_en = 1'b0;
    n_tests++;
    if (row_valid !== 1'b1 || row_data !== 8'h00) begin
      n_fail++; $display("FAIL coll_row3_cleared: vld=%b data=%h expected 1/00", row_valid, row_data);
    end
  endtask

`ifdef TRI_PIXBUF_BBOX_EN
  task automatic test_bbox();
    busy = 1'b1;
    step();
    n_tests++;
    if (bbox_valid !== 1'b0 || bbox_xmin !== 3'd7 || bbox_xmax !== 3'd0 ||
        bbox_ymin !== 3'd7 || bbox_ymax !== 3'd0) begin
      n_fail++; $display("FAIL bbox_start: v=%b x=%0d..%0d y=%0d..%0d expected 0 7..0 7..0",
                         bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax);
    end
    po = 1'b1; xo = 3'd2; yo = 3'd6;
    step();
    xo = 3'd4; yo = 3'd1;
    step();
    po = 1'b0; busy = 1'b0;
    step();
    n_tests++;
    if (bbox_valid !== 1'b1 || bbox_xmin !== 3'd2 || bbox_xmax !== 3'd4 ||
        bbox_ymin !== 3'd1 || bbox_ymax !== 3'd6) begin
      n_fail++; $display("FAIL bbox_final: v=%b x=%0d..%0d y=%0d..%0d expected 1 2..4 1..6",
                         bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0; busy = 1'b0; po = 1'b0; xo = '0; yo = '0; rd_en = 1'b0; rd_row = '0;
    step();
    step();
    reset = 1'b1;
    step();
    test_reset();
    test_basic_frame();
    test_duplicate();
    test_full_grid();
    test_collision();
`ifdef TRI_PIXBUF_BBOX_EN
    test_bbox();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
